// File: rtl/fetch_stage_pkg.sv
// Shared fetch-side definitions: FSM state encoding and fetch constants.
// Also imported by the hazard unit and the decode stage.
package fetch_stage_pkg;

    typedef enum logic {
        ST_REQ  = 1'b0,
        ST_HOLD = 1'b1
    } fetch_state_e;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
    localparam int unsigned PC_INCR   = 4;

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register: load wins over bubble; with neither asserted the
// contents hold.
module if_id_reg #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic             bubble_i,
    input  logic [WIDTH-1:0] instr_i,
    input  logic [WIDTH-1:0] pc4_i,
    output logic [WIDTH-1:0] instr_o,
    output logic [WIDTH-1:0] pc4_o,
    output logic             valid_o
);
    import fetch_stage_pkg::*;

    logic [WIDTH-1:0] instr_q;
    logic [WIDTH-1:0] pc4_q;
    logic             valid_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_q <= WIDTH'(NOP_INSTR);
            pc4_q   <= '0;
            valid_q <= 1'b0;
        end else if (load_i) begin
            instr_q <= instr_i;
            pc4_q   <= pc4_i;
            valid_q <= 1'b1;
        end else if (bubble_i) begin
            instr_q <= WIDTH'(NOP_INSTR);
            pc4_q   <= '0;
            valid_q <= 1'b0;
        end
    end

    assign instr_o = instr_q;
    assign pc4_o   = pc4_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC, memory request, hold buffer for words that
// return while decode is stalled, and the IF/ID register.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter int          WIDTH    = 32,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] npc_in,
    output logic [WIDTH-1:0] pc_plus4,
    input  logic             stall,
    input  logic             flush,
    output logic             imem_req,
    output logic [WIDTH-1:0] imem_addr,
    input  logic [WIDTH-1:0] imem_rdata,
    input  logic             imem_ready,
    output logic [WIDTH-1:0] if_id_instr,
    output logic [WIDTH-1:0] if_id_pc4,
    output logic             if_id_valid,
    output logic             dbg_state_o
);

    // Memory handshake: a word transfers in a cycle where imem_req and
    // imem_ready are both high; imem_ready outside a request is ignored.

    fetch_state_e     state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] buf_q, buf_d;
    logic             ld_load, ld_bubble;
    logic [WIDTH-1:0] ld_instr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_REQ;
            pc_q    <= WIDTH'(RESET_PC);
            buf_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            buf_q   <= buf_d;
        end
    end

    assign pc_plus4 = pc_q + WIDTH'(PC_INCR);

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        buf_d     = buf_q;
        ld_load   = 1'b0;
        ld_bubble = 1'b0;
        ld_instr  = imem_rdata;
        if (flush) begin
            state_d   = ST_REQ;
            pc_d      = npc_in;
            buf_d     = '0;
            ld_bubble = 1'b1;
        end else begin
            case (state_q)
                ST_REQ: begin
                    if (imem_ready && !stall) begin
                        ld_load = 1'b1;
                        pc_d    = npc_in;
                    end else if (imem_ready) begin
                        // Word arrived but decode is stalled: park it, no refetch.
                        buf_d   = imem_rdata;
                        state_d = ST_HOLD;
                    end else if (!stall) begin
                        ld_bubble = 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (!stall) begin
                        ld_load  = 1'b1;
                        ld_instr = buf_q;
                        pc_d     = npc_in;
                        state_d  = ST_REQ;
                    end
                end
                default: state_d = ST_REQ;
            endcase
        end
    end

    assign imem_req    = rst_n && (state_q == ST_REQ);
    assign imem_addr   = pc_q;
    assign dbg_state_o = state_q;

    if_id_reg #(.WIDTH(WIDTH)) u_if_id (
        .clk      (clk),
        .rst_n    (rst_n),
        .load_i   (ld_load),
        .bubble_i (ld_bubble),
        .instr_i  (ld_instr),
        .pc4_i    (pc_plus4),
        .instr_o  (if_id_instr),
        .pc4_o    (if_id_pc4),
        .valid_o  (if_id_valid)
    );

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed fetch scenarios with expected IF/ID
// contents queued at drive time and compared after each clock edge.
module tb_fetch_stage;

    localparam int W  = 32;
    localparam int EW = 2 * W + 1;

    logic          clk;
    logic          rst_n;
    logic [W-1:0]  npc_in;
    logic [W-1:0]  pc_plus4;
    logic          stall;
    logic          flush;
    logic          imem_req;
    logic [W-1:0]  imem_addr;
    logic [W-1:0]  imem_rdata;
    logic          imem_ready;
    logic [W-1:0]  if_id_instr;
    logic [W-1:0]  if_id_pc4;
    logic          if_id_valid;
    logic          dbg_state;

    logic [EW-1:0] exp_q[$];
    int            total;
    int            bad;
    int            fetch_0x20;

    fetch_stage #(.WIDTH(W), .RESET_PC(32'h0000_0000)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .npc_in      (npc_in),
        .pc_plus4    (pc_plus4),
        .stall       (stall),
        .flush       (flush),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .imem_ready  (imem_ready),
        .if_id_instr (if_id_instr),
        .if_id_pc4   (if_id_pc4),
        .if_id_valid (if_id_valid),
        .dbg_state_o (dbg_state)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [EW-1:0] got, input logic [EW-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [EW-1:0] ifid(input logic [W-1:0] instr, input logic [W-1:0] pc4, input logic v);
        return {instr, pc4, v};
    endfunction

    // Driver: one cycle of stimulus, request-side checks before the edge,
    // IF/ID scoreboard check after it.
    task automatic step(input string tag, input logic rdy, input logic [W-1:0] rdata,
                        input logic stl, input logic fl, input logic [W-1:0] npc,
                        input logic [W-1:0] exp_addr, input logic exp_req,
                        input logic [EW-1:0] exp_ifid);
        logic [EW-1:0] e;
        logic [W-1:0]  exp_p4;
        @(negedge clk);
        imem_ready = rdy;
        imem_rdata = rdata;
        stall      = stl;
        flush      = fl;
        npc_in     = npc;
        #1;
        exp_p4 = exp_addr + 32'd4;
        check_eq({tag, ".addr"}, EW'(imem_addr), EW'(exp_addr));
        check_eq({tag, ".req"}, EW'(imem_req), EW'(exp_req));
        check_eq({tag, ".pc4"}, EW'(pc_plus4), EW'(exp_p4));
        if (imem_req && imem_ready && imem_addr == 32'h20) fetch_0x20++;
        exp_q.push_back(exp_ifid);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check_eq({tag, ".ifid"}, ifid(if_id_instr, if_id_pc4, if_id_valid), e);
    endtask

    initial begin
        logic [W-1:0] r0, r1, r2;
        logic [EW-1:0] held;
        total = 0;
        bad = 0;
        fetch_0x20 = 0;
        rst_n = 1'b0;
        npc_in = '0;
        stall = 1'b0;
        flush = 1'b0;
        imem_ready = 1'b0;
        imem_rdata = '0;
        r0 = $urandom; r1 = $urandom; r2 = $urandom_range(32'h7fff_ffff, 1);

        // Reset values
        repeat (2) @(negedge clk);
        #1;
        check_eq("rst.req", EW'(imem_req), EW'(1'b0));
        check_eq("rst.addr", EW'(imem_addr), EW'(32'h0));
        check_eq("rst.ifid", ifid(if_id_instr, if_id_pc4, if_id_valid), ifid(32'h0, 32'h0, 1'b0));
        rst_n = 1'b1;

        // Zero-wait streaming
        step("zw0", 1, r0, 0, 0, 32'h4, 32'h0, 1, ifid(r0, 32'h4, 1));
        step("zw1", 1, r1, 0, 0, 32'h8, 32'h4, 1, ifid(r1, 32'h8, 1));
        step("zw2", 1, r2, 0, 0, 32'h10, 32'h8, 1, ifid(r2, 32'hC, 1));

        // Two wait states at 0x10
        step("ws0", 0, 32'hFFFF_FFFF, 0, 0, 32'h14, 32'h10, 1, ifid(32'h0, 32'h0, 0));
        step("ws1", 0, 32'hFFFF_FFFF, 0, 0, 32'h14, 32'h10, 1, ifid(32'h0, 32'h0, 0));
        step("ws2", 1, 32'h8C22_0004, 0, 0, 32'h20, 32'h10, 1, ifid(32'h8C22_0004, 32'h14, 1));

        // Stall for 3 cycles while the word at 0x20 returns
        held = ifid(32'h8C22_0004, 32'h14, 1);
        step("st0", 1, 32'h0043_0820, 1, 0, 32'h24, 32'h20, 1, held);
        check_eq("st0.state", EW'(dbg_state), EW'(1'b1));
        step("st1", 1, 32'hDEAD_BEEF, 1, 0, 32'h24, 32'h20, 0, held);
        step("st2", 1, 32'hDEAD_BEEF, 1, 0, 32'h24, 32'h20, 0, held);
        step("st3", 0, 32'hDEAD_BEEF, 0, 0, 32'h24, 32'h20, 0, ifid(32'h0043_0820, 32'h24, 1));
        check_eq("st.once", EW'(fetch_0x20), EW'(1));

        // Flush while in HOLD and stalled, then branch to the wrap address
        held = ifid(32'h0043_0820, 32'h24, 1);
        step("fl0", 1, 32'hAAAA_0001, 1, 0, 32'h28, 32'h24, 1, held);
        step("fl1", 1, 32'hBBBB_0002, 1, 1, 32'h400, 32'h24, 0, ifid(32'h0, 32'h0, 0));
        check_eq("fl1.state", EW'(dbg_state), EW'(1'b0));
        step("fl2", 1, 32'h1234_5678, 0, 0, 32'hFFFF_FFFC, 32'h400, 1, ifid(32'h1234_5678, 32'h404, 1));

        // PC wrap
        step("wrap", 1, 32'h0BAD_C0DE, 0, 0, 32'h0, 32'hFFFF_FFFC, 1, ifid(32'h0BAD_C0DE, 32'h0, 1));
        step("pre", 1, 32'h0000_0055, 0, 0, 32'h80, 32'h0, 1, ifid(32'h55, 32'h4, 1));

        // Asynchronous reset mid-wait, between edges
        @(negedge clk);
        imem_ready = 1'b0;
        stall = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("arst.req", EW'(imem_req), EW'(1'b0));
        check_eq("arst.addr", EW'(imem_addr), EW'(32'h0));
        check_eq("arst.ifid", ifid(if_id_instr, if_id_pc4, if_id_valid), ifid(32'h0, 32'h0, 0));
        @(negedge clk);
        rst_n = 1'b1;
        step("rst2", 1, 32'h0000_0066, 0, 0, 32'h4, 32'h0, 1, ifid(32'h66, 32'h4, 1));

        check_eq("sb.empty", EW'(exp_q.size()), EW'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
